mem_burst_ctrl: RTL and testbench
=================================

MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, number of addressable words in the downstream memory.
REQ-002 Parameter ADDR_STEP, default 4, address increment between consecutive beats.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  burst request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_write  input  1  1 = write burst, 0 = read burst.
REQ-008 req_addr  input  32  start address.
REQ-009 req_len  input  4  beat count minus one (1..16 beats).
REQ-010 wr_valid  input  1  write data beat present.
REQ-011 wr_ready  output  1  write beat accepted this cycle.
REQ-012 wr_data  input  32  write data.
REQ-013 rd_valid  output  1  read data beat present.
REQ-014 rd_ready  input  1  consumer accepts read beat.
REQ-015 rd_data  output  32  read data.
REQ-016 rd_last  output  1  final beat of read burst.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_read  output  1  memory read strobe, sampled by memory at posedge.
REQ-020 mem_write  output  1  memory write strobe, sampled by memory at posedge.
REQ-021 mem_rdata  input  32  memory read data; valid the cycle after the mem_read posedge; held while mem_read=0.
REQ-022 done  output  1  one-cycle pulse after burst completes.
REQ-023 err  output  1  one-cycle pulse, coincident with done, for a rejected burst.

Function
REQ-024 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_DATA, FIN.
REQ-025 IDLE: req_ready=1; on req_valid, latch addr, beats, direction; the range check of REQ-031 SHALL select the next state.
REQ-026 WR: wr_ready=1; on wr_valid, the controller SHALL drive mem_write=1, mem_addr=cur_addr, mem_wdata=wr_data combinationally in the same cycle; cur_addr+=ADDR_STEP; remaining-=1; on the last beat go to FIN.
REQ-027 RD_ISSUE: the controller SHALL assert mem_read=1 with mem_addr=cur_addr for exactly one cycle, then go to RD_DATA.
REQ-028 RD_DATA: rd_valid=1, rd_data=mem_rdata, rd_last=1 on the final beat; with rd_ready=0 the controller SHALL hold all outputs stable, with mem_read=0; on rd_ready=1, final beat goes to FIN, otherwise cur_addr+=ADDR_STEP and go to RD_ISSUE.
REQ-029 Read throughput SHALL be one beat per two cycles minimum; write throughput SHALL be one beat per cycle.
REQ-030 FIN: done=1 for one cycle, then return to IDLE; req_ready=0 in FIN.
REQ-031 A burst with start word index (req_addr/ADDR_STEP)+req_len >= MEM_DEPTH, or req_addr not a multiple of ADDR_STEP, SHALL go directly to FIN with err=1, no memory strobes and no wr_ready/rd_valid.
REQ-032 Address arithmetic SHALL be 32-bit unsigned; the controller SHALL not wrap past MEM_DEPTH, since REQ-031 prevents it.
REQ-033 mem_read and mem_write SHALL never both be 1; both SHALL be 0 outside WR and RD_ISSUE.
REQ-034 wr_valid in non-WR states SHALL be ignored; req_valid outside IDLE SHALL be ignored (not accepted).

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, with req_ready=1 once released, and all other outputs 0, including mem_addr and mem_wdata.
REQ-036 Reset mid-burst SHALL abort the burst with no done pulse; beats already written remain in memory.

Verification
REQ-037 Write req_addr=16, req_len=1, beats 12345678, 89abcdef, wr_valid held -> mem writes at 16, 20 on consecutive posedges; done one cycle after beat 2; err=0.
REQ-038 Read req_addr=16, req_len=1, rd_ready=1 -> rd_data 12345678 then 89abcdef; rd_last only on beat 2; done follows.
REQ-039 Same read with rd_ready low 3 cycles on beat 1 -> rd_data stable at 12345678, mem_read=0 throughout stall, no duplicate or lost beat.
REQ-040 req_addr=4088, req_len=3 (index 1022+3 >= 1024) -> err=1 and done=1 in the same cycle, zero memory strobes; also req_addr=18 -> err.
REQ-041 rst_n low after first of 4 write beats -> outputs 0 asynchronously, no done; a following read of 16 returns the first beat's data.
REQ-042 Back-to-back requests with req_valid held -> second accepted in the IDLE cycle after FIN; 16-beat burst at 0 ends with cur_addr 60 on the last beat.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Burst controller: turns one read/write burst request into per-beat memory strobes,
// with range/alignment rejection and a done/err completion pulse.
module mem_burst_ctrl #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_DATA, FIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  rem_q, rem_d;
    logic        err_q, err_d;

    logic [32:0] word_idx;
    logic [32:0] end_idx;
    logic        misaligned;
    logic        reject;

    // 33-bit so that the end word index cannot overflow for addresses near 2^32.
    always_comb begin
        word_idx   = {1'b0, req_addr} / 33'(ADDR_STEP);
        end_idx    = word_idx + 33'(req_len);
        misaligned = (req_addr % 32'(ADDR_STEP)) != '0;
        reject     = misaligned || (end_idx >= 33'(MEM_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    rem_d  = req_len;
                    err_d  = reject;
                    if (reject)         state_d = FIN;
                    else if (req_write) state_d = WR;
                    else                state_d = RD_ISSUE;
                end
            end
            WR: begin
                if (wr_valid) begin
                    addr_d = addr_q + 32'(ADDR_STEP);
                    rem_d  = rem_q - 4'd1;
                    if (rem_q == '0) state_d = FIN;
                end
            end
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA: begin
                if (rd_ready) begin
                    if (rem_q == '0) begin
                        state_d = FIN;
                    end else begin
                        addr_d  = addr_q + 32'(ADDR_STEP);
                        rem_d   = rem_q - 4'd1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            WR: begin
                wr_ready = 1'b1;
                mem_addr = addr_q;
                if (wr_valid) begin
                    mem_write = 1'b1;
                    mem_wdata = wr_data;
                end
            end
            RD_ISSUE: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
            end
            RD_DATA: begin
                rd_valid = 1'b1;
                rd_data  = mem_rdata;
                rd_last  = (rem_q == '0);
                mem_addr = addr_q;
            end
            FIN: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: directed table, reset/back-to-back sequences,
// and random bursts checked against a word-array reference of the memory contents.
module tb_mem_burst_ctrl;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned STEP  = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata = '0;
    logic        done;
    logic        err;

    mem_burst_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] init_val(input int unsigned i);
        return 32'hA5A5_0000 ^ (i * 32'h0001_9E37);
    endfunction

    // Downstream memory: one-cycle read latency, read data held between reads.
    logic [31:0] tb_mem [DEPTH];
    bit          tb_vld [DEPTH];
    logic [31:0] midx;
    int unsigned n_mw = 0, n_mr = 0, n_both = 0;
    assign midx = mem_addr / STEP;

    always @(posedge clk) begin
        if (mem_write) begin
            n_mw <= n_mw + 1;
            if (midx < DEPTH) begin
                tb_mem[midx[9:0]] <= mem_wdata;
                tb_vld[midx[9:0]] <= 1'b1;
            end
        end
        if (mem_read) begin
            n_mr <= n_mr + 1;
            if (midx < DEPTH)
                mem_rdata <= tb_vld[midx[9:0]] ? tb_mem[midx[9:0]] : init_val(midx);
        end
        if (mem_read && mem_write) n_both <= n_both + 1;
    end

    // Reference: expected memory contents per word, plus the acceptance rule.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] fixed_pat [2];

    function automatic bit ref_bad(input logic [31:0] a, input logic [3:0] l);
        return ((a % STEP) != 0) || ((64'(a) / STEP + 64'(l)) >= 64'(DEPTH));
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  len;
        int unsigned gap;
        int unsigned stall;
        bit          hold;
        bit          fixed;
        bit          exp_err;
    } burst_t;

    burst_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flags"}, 32'({wr_ready, rd_valid, rd_last, mem_read, mem_write, done, err}), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
    endtask

    // Entered and left just after a negedge with the DUT in IDLE.
    task automatic do_burst(input burst_t b);
        int unsigned beats = 32'(b.len) + 1;
        int unsigned base  = b.addr / STEP;
        int unsigned wb = 0, rb = 0, cyc = 0;
        int unsigned stall_left = b.stall;
        int unsigned mw0 = n_mw, mr0 = n_mr;
        bit saw_done = 0, last_prev = 0, saw_beat_if = 0;
        req_valid = 1'b1;
        req_write = b.wr;
        req_addr  = b.addr;
        req_len   = b.len;
        #1 check("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        if (!b.hold) req_valid = 1'b0;
        while (!saw_done && cyc < 400) begin
            wr_valid = ($urandom_range(99) >= b.gap);
            if (b.fixed && wb < 2) wr_data = fixed_pat[wb];
            else                   wr_data = $urandom;
            rd_ready = ($urandom_range(99) >= b.gap);
            #1;
            if (rd_valid && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
                #1;
            end
            check("done_timing", 32'(done), 32'(b.exp_err ? (cyc == 0) : last_prev));
            last_prev = 0;
            if (wr_ready || rd_valid) saw_beat_if = 1;
            if (mem_read) check("rd_issue_addr", mem_addr, b.addr + rb * STEP);
            if (wr_ready && wr_valid) begin
                check("wr_strobe", 32'(mem_write), 32'd1);
                check("wr_addr", mem_addr, b.addr + wb * STEP);
                check("wr_data", mem_wdata, wr_data);
                if (base + wb < DEPTH) ref_mem[10'(base + wb)] = wr_data;
                last_prev = (wb == 32'(b.len));
                wb++;
            end
            if (rd_valid) begin
                if (base + rb < DEPTH)
                    check(rd_ready ? "rd_data" : "rd_stall_data", rd_data, ref_mem[10'(base + rb)]);
                check("rd_last", 32'(rd_last), 32'(rb == 32'(b.len)));
                if (!rd_ready) begin
                    check("rd_stall_no_read", 32'(mem_read), 32'd0);
                end else begin
                    last_prev = (rb == 32'(b.len));
                    rb++;
                end
            end
            if (done) begin
                saw_done = 1;
                check("err_flag", 32'(err), 32'(b.exp_err));
                check("fin_req_ready", 32'(req_ready), 32'd0);
                if (b.gap == 0 && b.stall == 0 && !b.exp_err)
                    check("burst_cycles", cyc, b.wr ? beats : 2 * beats);
            end
            @(negedge clk);
            cyc++;
        end
        check("burst_done_seen", 32'(saw_done), 32'd1);
        check("mem_write_count", n_mw - mw0, (b.exp_err || !b.wr) ? 0 : beats);
        check("mem_read_count", n_mr - mr0, (b.exp_err || b.wr) ? 0 : beats);
        if (b.exp_err) check("err_no_beat_if", 32'(saw_beat_if), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        burst_t      r;
        int unsigned mode;
        int unsigned mw0;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);
        fixed_pat[0] = 32'h1234_5678;
        fixed_pat[1] = 32'h89ab_cdef;

        //          wr    addr      len  gap stall hold fixed err
        tbl[0]  = '{1'b1, 32'd16,   4'd1,  0, 0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 32'd16,   4'd1,  0, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'd16,   4'd1,  0, 3, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'd4088, 4'd3,  0, 0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 32'd4088, 4'd3,  0, 0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'd18,   4'd0,  0, 0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 32'd4092, 4'd0,  0, 0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 32'd4088, 4'd1,  0, 0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'd4088, 4'd2,  0, 0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 32'd0,    4'd15, 0, 0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'd64,   4'd3,  0, 0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'd0,    4'd15, 25, 1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'd4094, 4'd0,  0, 0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b1; wr_data = '1; rd_ready = 1'b0;
        #3 check_quiet("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        #1 check("post_reset_req_ready", 32'(req_ready), 32'd1);
        check_quiet("post_reset");
        @(negedge clk);

        for (int i = 0; i < 13; i++) do_burst(tbl[i]);
        req_valid = 1'b0;

        // Reset after the first of four write beats: beat 1 stays in memory, no done.
        mw0 = n_mw;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd16; req_len = 4'd3;
        @(negedge clk);
        req_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hCAFE_0001;
        #1 check("rst_seq_beat1_strobe", 32'(mem_write), 32'd1);
        ref_mem[4] = 32'hCAFE_0001;
        @(negedge clk);
        wr_data = 32'hCAFE_0002;
        #2 rst_n = 1'b0;
        #1 check_quiet("async_reset");
        @(negedge clk);
        check_quiet("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        #1 check("rst_release_req_ready", 32'(req_ready), 32'd1);
        check("rst_release_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("rst_seq_write_count", n_mw - mw0, 32'd1);
        r = '{1'b0, 32'd16, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0};
        do_burst(r);
        r = '{1'b0, 32'd20, 4'd0, 0, 0, 1'b0, 1'b0, 1'b0};
        do_burst(r);

        for (int unsigned i = 0; i < 40; i++) begin
            mode   = $urandom_range(9);
            r.wr   = 1'($urandom_range(1));
            r.len  = 4'($urandom_range(15));
            if (mode == 0)     r.addr = $urandom_range(1023) * STEP + $urandom_range(3, 1);
            else if (mode < 3) r.addr = $urandom_range(1023, 1000) * STEP;
            else               r.addr = $urandom_range(1000) * STEP;
            r.gap     = $urandom_range(40);
            r.stall   = $urandom_range(2);
            r.hold    = ($urandom_range(3) == 0);
            r.fixed   = 1'b0;
            r.exp_err = ref_bad(r.addr, r.len);
            do_burst(r);
        end

        req_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("never_read_and_write", n_both, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
